// File: rtl/fetch_decode_queue_pkg.sv
// Shared decode-side definitions: NOP encoding and the queued {instr, pc} entry.
package rv_pkg;

  localparam int          FQ_IWIDTH   = 32;
  localparam int          FQ_PC_WIDTH = 32;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;  // addi x0, x0, 0

  typedef struct packed {
    logic [FQ_IWIDTH-1:0]   instr;
    logic [FQ_PC_WIDTH-1:0] pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_decode_queue_if.sv
// Fetch/decode handshake bundle; master = fetch+decode side, slave = the queue.
interface fetch_decode_queue_if #(
  parameter int IWIDTH   = 32,
  parameter int PC_WIDTH = 32,
  parameter int DEPTH    = 4
);
  localparam int CWIDTH = $clog2(DEPTH) + 1;

  logic [IWIDTH-1:0]   fq_i_instr;
  logic [PC_WIDTH-1:0] fq_i_pc;
  logic                fq_i_ce;
  logic                fq_o_stall;
  logic                fq_i_flush;
  logic                fq_o_flush;
  logic [IWIDTH-1:0]   fq_o_instr;
  logic [PC_WIDTH-1:0] fq_o_pc;
  logic                fq_o_ce;
  logic                fq_i_stall;
  logic [CWIDTH-1:0]   fq_o_count;

  modport master (
    output fq_i_instr, fq_i_pc, fq_i_ce, fq_i_flush, fq_i_stall,
    input  fq_o_stall, fq_o_flush, fq_o_instr, fq_o_pc, fq_o_ce, fq_o_count
  );

  modport slave (
    input  fq_i_instr, fq_i_pc, fq_i_ce, fq_i_flush, fq_i_stall,
    output fq_o_stall, fq_o_flush, fq_o_instr, fq_o_pc, fq_o_ce, fq_o_count
  );

endinterface

// File: rtl/fetch_decode_queue_mem.sv
// Entry storage: DEPTH x WIDTH registers, one sync write port, one async read port, no data reset.
module fetch_decode_queue_mem #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_decode_queue.sv
// Instruction queue between fetch and decode with flush forwarding.
// Optional zero-latency empty-queue bypass enabled by FETCH_DECODE_QUEUE_BYPASS_EN.
module fetch_decode_queue
  import rv_pkg::*;
#(
  parameter int IWIDTH   = 32,
  parameter int PC_WIDTH = 32,
  parameter int DEPTH    = 4
) (
  input  logic               fq_clk,
  input  logic               fq_rst,
  fetch_decode_queue_if.slave bus
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CWIDTH = AW + 1;
  localparam int EW     = IWIDTH + PC_WIDTH;

  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [CWIDTH-1:0] count;
  logic              flush_q;
  logic              full, head_vld, byp, wr, rd;
  logic [EW-1:0]     head;

  // Stall comes only from registered count, so fetch never sees decode's stall combinationally.
  assign full     = (count == CWIDTH'(DEPTH));
  assign head_vld = (count != '0);

`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
  assign byp = ~head_vld & bus.fq_i_ce & ~bus.fq_i_flush;
`else
  assign byp = 1'b0;
`endif

  // A bypassed entry that decode accepts immediately never touches storage.
  assign rd = head_vld & ~bus.fq_i_stall;
  assign wr = bus.fq_i_ce & ~full & ~(byp & ~bus.fq_i_stall);

  always_ff @(posedge fq_clk) begin
    if (fq_rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      flush_q <= 1'b0;
    end else begin
      flush_q <= bus.fq_i_flush;
      if (bus.fq_i_flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        wr_ptr <= wr_ptr + AW'(wr);
        rd_ptr <= rd_ptr + AW'(rd);
        count  <= count + CWIDTH'(wr) - CWIDTH'(rd);
      end
    end
  end

  fetch_decode_queue_mem #(.WIDTH(EW), .DEPTH(DEPTH)) u_mem (
    .clk   (fq_clk),
    .we    (wr & ~bus.fq_i_flush),
    .waddr (wr_ptr),
    .wdata ({bus.fq_i_instr, bus.fq_i_pc}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_comb begin
    bus.fq_o_ce    = head_vld | byp;
    bus.fq_o_instr = IWIDTH'(NOP_INSTR);
    bus.fq_o_pc    = '0;
    if (byp) begin
      bus.fq_o_instr = bus.fq_i_instr;
      bus.fq_o_pc    = bus.fq_i_pc;
    end else if (head_vld) begin
      bus.fq_o_instr = head[EW-1:PC_WIDTH];
      bus.fq_o_pc    = head[PC_WIDTH-1:0];
    end
  end

  assign bus.fq_o_stall = full;
  assign bus.fq_o_flush = flush_q;
  assign bus.fq_o_count = count;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Scoreboard bench for fetch_decode_queue; expected entries queued on accepted push, checked at the head.
module tb_fetch_decode_queue;
  import rv_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_decode_queue_if #(.IWIDTH(32), .PC_WIDTH(32), .DEPTH(DEPTH)) bus ();

  fetch_decode_queue #(.IWIDTH(32), .PC_WIDTH(32), .DEPTH(DEPTH)) dut (
    .fq_clk (clk),
    .fq_rst (rst),
    .bus    (bus)
  );

  fq_entry_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic exp_flush = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h @%0t", tag, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, check outputs against the model mid-cycle, then update the model.
  task automatic cycle(input logic ce, input logic [31:0] pc, input logic st, input logic fl);
    fq_entry_t e, h;
    logic byp, full, push, pop;
    e.instr = 32'hC0DE_0000 ^ pc;
    e.pc    = pc;
    bus.fq_i_ce    = ce;
    bus.fq_i_instr = e.instr;
    bus.fq_i_pc    = pc;
    bus.fq_i_stall = st;
    bus.fq_i_flush = fl;
    @(negedge clk);
    full = (sb.size() == DEPTH);
`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
    byp = (sb.size() == 0) && ce && !fl;
`else
    byp = 1'b0;
`endif
    if (sb.size() != 0) h = sb[0];
    else if (byp) h = e;
    else begin
      h.instr = NOP_INSTR;
      h.pc    = 32'h0;
    end
    chk("count", 64'(bus.fq_o_count), 64'(sb.size()));
    chk("stall", 64'(bus.fq_o_stall), 64'(full));
    chk("flush_out", 64'(bus.fq_o_flush), 64'(exp_flush));
    chk("ce", 64'(bus.fq_o_ce), 64'((sb.size() != 0) || byp));
    chk("instr", 64'(bus.fq_o_instr), 64'(h.instr));
    chk("pc", 64'(bus.fq_o_pc), 64'(h.pc));
    push = ce && !full;
    pop  = ((sb.size() != 0) || byp) && !st;
    if (fl) sb.delete();
    else begin
      if (pop && sb.size() != 0) void'(sb.pop_front());
      if (push && !(byp && pop)) sb.push_back(e);
    end
    exp_flush = fl;
    @(posedge clk);
    #1;
  endtask

  // Flush is held high during reset to show reset wins.
  task automatic do_reset();
    rst = 1'b1;
    bus.fq_i_ce    = 1'b0;
    bus.fq_i_instr = '0;
    bus.fq_i_pc    = '0;
    bus.fq_i_stall = 1'b0;
    bus.fq_i_flush = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.fq_i_flush = 1'b0;
    sb.delete();
    exp_flush = 1'b0;
  endtask

  initial begin
    do_reset();
    // idle after reset
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);

    // fill with decode stalled, fifth push dropped, then drain in order
    for (int i = 0; i < 4; i++) cycle(1, 32'(i * 4), 1, 0);
    cycle(1, 32'h10, 1, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);

    // full with simultaneous push+pop
    for (int i = 0; i < 4; i++) cycle(1, 32'h20 + 32'(i * 4), 1, 0);
    cycle(1, 32'h40, 0, 0);
    cycle(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);

    // flush with concurrent push while holding 3 entries, then a multi-cycle flush
    for (int i = 0; i < 3; i++) cycle(1, 32'h50 + 32'(i * 4), 1, 0);
    cycle(1, 32'h60, 1, 1);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 32'h64, 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, 32'h68 + 32'(i * 4), 0, 1);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);

    // streaming push+pop with one entry resident, pointers wrap
    cycle(1, 32'h80, 1, 0);
    for (int i = 0; i < 3 * DEPTH; i++) cycle(1, 32'h84 + 32'(i * 4), 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);

    // empty-queue push: bypass behaviour depends on build
    cycle(1, 32'h100, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 32'h104, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);

    // reset mid-operation discards contents
    cycle(1, 32'h200, 1, 0);
    cycle(1, 32'h204, 1, 0);
    do_reset();
    cycle(0, 0, 0, 0);
    cycle(1, 32'h208, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
